// File: rtl/bmw_task_dispatcher_pkg.sv
// Shared task encoding for the BMW task FIFO writer and the dispatcher.
// A task word is {op, tree_id, data}, op 1 = push, 0 = pop.
package bmw_task_pkg;

  localparam int BMW_PTW           = 16;
  localparam int BMW_MTW           = 16;
  localparam int BMW_TREE_NUM      = 4;
  localparam int BMW_TREE_NUM_BITS = $clog2(BMW_TREE_NUM);
  localparam int BMW_TREE_CAP      = 1024;
  localparam int BMW_OP_GAP        = 4;
  localparam int BMW_DATA_W        = BMW_PTW + BMW_MTW;
  localparam int BMW_TASK_W        = BMW_DATA_W + BMW_TREE_NUM_BITS + 1;

  typedef enum logic {
    OP_POP  = 1'b0,
    OP_PUSH = 1'b1
  } op_e;

  typedef struct packed {
    op_e                          op;
    logic [BMW_TREE_NUM_BITS-1:0] tree_id;
    logic [BMW_DATA_W-1:0]        data;
  } task_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bmw_task_dispatcher_if.sv
// Task FIFO read port plus tree array command port of the dispatcher.
// master = dispatcher, slave = FIFO/tree-array environment.
interface bmw_task_dispatcher_if
  import bmw_task_pkg::*;
#(
  parameter int PTW      = BMW_PTW,
  parameter int MTW      = BMW_MTW,
  parameter int TREE_NUM = BMW_TREE_NUM,
  parameter int TREE_CAP = BMW_TREE_CAP
) ();

  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
  localparam int CAP_BITS      = $clog2(TREE_CAP + 1);
  localparam int DATA_W        = PTW + MTW;
  localparam int TASK_W        = DATA_W + TREE_NUM_BITS + 1;

  logic                         fifo_empty_i;
  logic                         fifo_rd_en_o;
  logic [TASK_W-1:0]            fifo_data_i;
  // tree command: a transfer happens on a cycle with tree_valid_o && tree_ready_i;
  // once valid rises, valid/op/id/data stay stable until that transfer.
  logic                         tree_valid_o;
  logic                         tree_ready_i;
  logic                         tree_op_o;
  logic [TREE_NUM_BITS-1:0]     tree_id_o;
  logic [DATA_W-1:0]            tree_data_o;
  logic                         drop_o;
  logic [15:0]                  drop_cnt_o;
  logic [TREE_NUM*CAP_BITS-1:0] occ_o;
  logic                         busy_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, tree_ready_i,
    output fifo_rd_en_o, tree_valid_o, tree_op_o, tree_id_o, tree_data_o,
           drop_o, drop_cnt_o, occ_o, busy_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, tree_ready_i,
    input  fifo_rd_en_o, tree_valid_o, tree_op_o, tree_id_o, tree_data_o,
           drop_o, drop_cnt_o, occ_o, busy_o
  );

endinterface

// File: rtl/bmw_tree_slot.sv
// Per-tree bookkeeping: issue cooldown counter and occupancy counter.
module bmw_tree_slot #(
  parameter int OP_GAP   = 4,
  parameter int TREE_CAP = 1024,
  parameter int CAP_BITS = $clog2(TREE_CAP + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                dec,
  input  logic                load_cool,
  output logic                ready,
  output logic                full,
  output logic                empty,
  output logic [CAP_BITS-1:0] occ
);

  localparam int COOL_BITS = $clog2(OP_GAP + 1);

  logic [COOL_BITS-1:0] cool;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool <= '0;
      occ  <= '0;
    end else begin
      if (load_cool)
        cool <= COOL_BITS'(OP_GAP - 1);
      else if (cool != '0)
        cool <= cool - COOL_BITS'(1);
      if (inc)
        occ <= occ + CAP_BITS'(1);
      else if (dec)
        occ <= occ - CAP_BITS'(1);
    end
  end

  assign ready = (cool == '0);
  assign full  = (occ == CAP_BITS'(TREE_CAP));
  assign empty = (occ == '0);

endmodule

// File: rtl/bmw_task_dispatcher.sv
// Pops encoded tasks from the task FIFO, drops illegal ones and issues the
// rest in order to the PIFO tree array with a per-tree minimum spacing.
module bmw_task_dispatcher
  import bmw_task_pkg::*;
#(
  parameter int PTW      = BMW_PTW,
  parameter int MTW      = BMW_MTW,
  parameter int TREE_NUM = BMW_TREE_NUM,
  parameter int OP_GAP   = BMW_OP_GAP,
  parameter int TREE_CAP = BMW_TREE_CAP
) (
  input logic                   clk,
  input logic                   rst_n,
  bmw_task_dispatcher_if.master bus
);

  localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
  localparam int CAP_BITS      = $clog2(TREE_CAP + 1);
  localparam int DATA_W        = PTW + MTW;
  localparam int TASK_W        = DATA_W + TREE_NUM_BITS + 1;

  logic                     rd_pending;
  logic                     hold_valid;
  op_e                      hold_op;
  logic [TREE_NUM_BITS-1:0] hold_id;
  logic [DATA_W-1:0]        hold_data;
  logic [15:0]              drop_cnt;

  logic [TREE_NUM-1:0] slot_ready, slot_full, slot_empty;
  logic [TREE_NUM-1:0] inc, dec, load_cool;
  logic [CAP_BITS-1:0] occ [TREE_NUM];

  logic push_full, pop_empty, drop, tree_valid, transfer, hold_leaving, rd_en;

  assign push_full    = (hold_op == OP_PUSH) && slot_full[hold_id];
  assign pop_empty    = (hold_op == OP_POP) && slot_empty[hold_id];
  assign drop         = hold_valid && (push_full || pop_empty);
  assign tree_valid   = hold_valid && !drop && slot_ready[hold_id];
  assign transfer     = tree_valid && bus.tree_ready_i;
  assign hold_leaving = transfer || drop;
  // Refill the hold register in the same cycle it empties for 2-cycle throughput.
  assign rd_en        = !bus.fifo_empty_i && !rd_pending && (!hold_valid || hold_leaving);

  always_comb begin
    inc       = '0;
    dec       = '0;
    load_cool = '0;
    if (transfer) begin
      load_cool[hold_id] = 1'b1;
      if (hold_op == OP_PUSH)
        inc[hold_id] = 1'b1;
      else
        dec[hold_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      hold_valid <= 1'b0;
      hold_op    <= OP_POP;
      hold_id    <= '0;
      hold_data  <= '0;
      drop_cnt   <= '0;
    end else begin
      rd_pending <= rd_en;
      // The FIFO word is only meaningful the cycle after a read.
      if (rd_pending) begin
        hold_valid <= 1'b1;
        hold_op    <= op_e'(bus.fifo_data_i[TASK_W-1]);
        hold_id    <= bus.fifo_data_i[DATA_W +: TREE_NUM_BITS];
        hold_data  <= bus.fifo_data_i[DATA_W-1:0];
      end else if (hold_leaving) begin
        hold_valid <= 1'b0;
      end
      if (drop)
        drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  for (genvar t = 0; t < TREE_NUM; t++) begin : g_slot
    bmw_tree_slot #(
      .OP_GAP   (OP_GAP),
      .TREE_CAP (TREE_CAP),
      .CAP_BITS (CAP_BITS)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc[t]),
      .dec       (dec[t]),
      .load_cool (load_cool[t]),
      .ready     (slot_ready[t]),
      .full      (slot_full[t]),
      .empty     (slot_empty[t]),
      .occ       (occ[t])
    );
    assign bus.occ_o[t*CAP_BITS +: CAP_BITS] = occ[t];
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.tree_valid_o = tree_valid;
  assign bus.tree_op_o    = (hold_op == OP_PUSH);
  assign bus.tree_id_o    = hold_id;
  assign bus.tree_data_o  = (hold_op == OP_PUSH) ? hold_data : '0;
  assign bus.drop_o       = drop;
  assign bus.drop_cnt_o   = drop_cnt;
  assign bus.busy_o       = rd_pending || hold_valid;

endmodule

// File: tb/tb_bmw_task_dispatcher.sv
// Scoreboard bench for bmw_task_dispatcher: a task-order reference model fills
// the expected queue, a negedge monitor checks every issue/drop the DUT shows.
module tb_bmw_task_dispatcher;

  localparam int PTW      = 16;
  localparam int MTW      = 16;
  localparam int TREE_NUM = 4;
  localparam int OP_GAP   = 4;
  localparam int TREE_CAP = 4;
  localparam int TNB      = 2;
  localparam int CAP_BITS = $clog2(TREE_CAP + 1);
  localparam int DATA_W   = PTW + MTW;
  localparam int TASK_W   = DATA_W + TNB + 1;
  localparam int EW       = 1 + 1 + TNB + DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bmw_task_dispatcher_if #(
    .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .TREE_CAP(TREE_CAP)
  ) bus ();

  bmw_task_dispatcher #(
    .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .OP_GAP(OP_GAP), .TREE_CAP(TREE_CAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [EW-1:0]     exp_q[$];
  logic [TASK_W-1:0] tq[$];
  int                issue_log[$];
  int                model_occ[TREE_NUM];
  int                model_drops;
  bit                ready_rand;
  logic              ready_val;

  // ---------------- clock / cycle counter ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int occ_of(input int t);
    return int'(bus.occ_o[t*CAP_BITS +: CAP_BITS]);
  endfunction

  // ---------------- reference model + driver ----------------
  task automatic send(input bit op, input int id, input logic [DATA_W-1:0] data);
    logic [TNB-1:0] tid;
    tid = TNB'(id);
    if ((op && model_occ[id] == TREE_CAP) || (!op && model_occ[id] == 0)) begin
      exp_q.push_back({1'b1, op, tid, data});
      if (model_drops < 65535) model_drops++;
    end else begin
      exp_q.push_back({1'b0, op, tid, op ? data : {DATA_W{1'b0}}});
      model_occ[id] += op ? 1 : -1;
    end
    tq.push_back({op, tid, data});
  endtask

  task automatic model_reset();
    exp_q.delete();
    tq.delete();
    issue_log.delete();
    model_drops = 0;
    for (int t = 0; t < TREE_NUM; t++) model_occ[t] = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((tq.size() != 0 || exp_q.size() != 0 || bus.busy_o || !bus.fifo_empty_i) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      fails++;
      $display("FAIL %s: drain timeout, %0d expected events left", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, output int at);
    int n;
    n = 0;
    at = -1;
    while (!bus.tree_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.tree_valid_o) at = cyc;
    else begin
      checks++;
      fails++;
      $display("FAIL %s: tree_valid_o never rose", name);
    end
  endtask

  task automatic check_state(input string tag);
    for (int t = 0; t < TREE_NUM; t++)
      check($sformatf("%s_occ%0d", tag, t), 64'(occ_of(t)), 64'(model_occ[t]));
    check({tag, "_drop_cnt"}, 64'(bus.drop_cnt_o), 64'(model_drops));
  endtask

  // Task FIFO model: word appears the cycle after rd_en, zero otherwise.
  initial begin
    bit rd_now;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i  = '0;
    forever begin
      @(negedge clk);
      rd_now = rst_n && bus.fifo_rd_en_o;
      @(posedge clk);
      #1;
      if (rd_now && rst_n && tq.size() > 0) bus.fifo_data_i = tq.pop_front();
      else                                  bus.fifo_data_i = '0;
      bus.fifo_empty_i = (tq.size() == 0);
    end
  end

  initial begin
    bus.tree_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tree_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] prev_word;
    bit            prev_stall;
    int            last_issue[TREE_NUM];
    prev_stall = 0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        for (int t = 0; t < TREE_NUM; t++) last_issue[t] = -1000;
      end else begin
        if (prev_stall)
          check("stall_stable", {bus.tree_valid_o, bus.tree_op_o, bus.tree_id_o, bus.tree_data_o},
                {1'b1, prev_word[EW-2:0]});
        if (bus.tree_valid_o && bus.drop_o)
          check("valid_with_drop", 64'(1), 64'(0));
        if ((bus.tree_valid_o && bus.tree_ready_i) || bus.drop_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: drop=%0b id=%0d with empty expected queue",
                     bus.drop_o, bus.tree_id_o);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(bus.drop_o), 64'(e[EW-1]));
            if (!bus.drop_o) begin
              check("issue", {1'b0, bus.tree_op_o, bus.tree_id_o, bus.tree_data_o}, e);
              check("tree_gap", 64'(cyc - last_issue[bus.tree_id_o] >= OP_GAP), 64'(1));
              last_issue[bus.tree_id_o] = cyc;
              issue_log.push_back(cyc);
            end
          end
        end
        prev_stall = bus.tree_valid_o && !bus.tree_ready_i;
        prev_word  = {1'b0, bus.tree_op_o, bus.tree_id_o, bus.tree_data_o};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, c1, n, seen;
    ready_rand = 0;
    ready_val  = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_rd_en", 64'(bus.fifo_rd_en_o), 0);
    check("rst_valid", 64'(bus.tree_valid_o), 0);
    check("rst_cmd", {bus.tree_op_o, bus.tree_id_o, bus.tree_data_o}, 0);
    check("rst_drop", 64'(bus.drop_o), 0);
    check("rst_busy", 64'(bus.busy_o), 0);
    check_state("rst");
    #2 rst_n = 1'b1;

    // single push: latency from rd_en to tree_valid_o is 2 cycles
    @(negedge clk);
    send(1'b1, 2, 32'h1234_5678);
    n = 0;
    while (!bus.fifo_rd_en_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    c0 = cyc;
    wait_valid("latency", c1);
    check("latency", 64'(c1 - c0), 64'(2));
    wait_drain("push_t2");
    check_state("push_t2");

    // pop to empty tree 1: dropped
    send(1'b0, 1, 32'hDEAD_BEEF);
    wait_drain("pop_empty");
    check_state("pop_empty");

    // two pushes to tree 0 then tree 3: exact spacing and head-of-line wait
    issue_log.delete();
    send(1'b1, 0, $urandom);
    send(1'b1, 0, $urandom);
    send(1'b1, 3, $urandom);
    wait_drain("gap");
    check("gap_count", 64'(issue_log.size()), 64'(3));
    if (issue_log.size() == 3) begin
      check("gap_same_tree", 64'(issue_log[1] - issue_log[0]), 64'(OP_GAP));
      check("gap_hol", 64'(issue_log[2] - issue_log[0]), 64'(OP_GAP + 2));
    end
    check_state("gap");

    // stalled tree_ready_i for 5 cycles
    ready_val = 1'b0;
    send(1'b1, 1, $urandom);
    wait_valid("stall", c1);
    repeat (5) @(negedge clk);
    ready_val = 1'b1;
    wait_drain("stall");
    check_state("stall");

    // fill tree 0 to capacity, overflow push dropped, then pop and push
    send(1'b1, 0, $urandom);
    send(1'b1, 0, $urandom);
    send(1'b1, 0, $urandom);
    send(1'b0, 0, $urandom);
    send(1'b1, 0, $urandom);
    wait_drain("fill");
    check("fill_occ0", 64'(occ_of(0)), 64'(TREE_CAP));
    check_state("fill");

    // random traffic with random back-pressure
    ready_rand = 1;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, TREE_NUM - 1), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("random");
    ready_rand = 0;
    ready_val  = 1'b1;
    check_state("random");

    // reset while a task is held stalled and another waits in the FIFO
    ready_val = 1'b0;
    send(1'b1, 2, $urandom);
    send(1'b1, 3, $urandom);
    wait_valid("rst_mid", c1);
    check("rst_mid_busy", 64'(bus.busy_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_valid", 64'(bus.tree_valid_o), 0);
    check("rst_mid_rd_en", 64'(bus.fifo_rd_en_o), 0);
    check("rst_mid_busy0", 64'(bus.busy_o), 0);
    check("rst_mid_cmd", {bus.tree_op_o, bus.tree_id_o, bus.tree_data_o}, 0);
    check_state("rst_mid");
    ready_val = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tree_valid_o || bus.busy_o) seen++;
    end
    check("no_issue_after_rst", 64'(seen), 0);
    send(1'b1, 1, 32'hCAFE_0001);
    wait_drain("after_rst");
    check_state("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bmw_task_dispatcher.md
# bmw_task_dispatcher

Downstream consumer of the task FIFO: pops one encoded push/pop task at a time, decodes it, and issues it to the BMW PIFO tree array. Enforces a minimum per-tree spacing between operations (SRAM-tree pipeline constraint), and tracks per-tree occupancy. Illegal tasks are dropped and counted: pops to an empty tree, pushes to a full tree. Sits between the task FIFO read port and the tree array's command port.

## Interface
- PTW, 16, payload width
- MTW, 16, metadata width
- TREE_NUM, 4, number of logical trees
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width
- OP_GAP, 4, minimum cycles between two issues to the same tree (≥1; 1 = no constraint)
- TREE_CAP, 1024, elements one tree can hold
- CAP_BITS, $clog2(TREE_CAP+1), occupancy counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- fifo_empty_i  in  1  task FIFO empty flag
- fifo_rd_en_o  out  1  task FIFO read enable
- fifo_data_i  in  PTW+MTW+TREE_NUM_BITS+1  task FIFO read data, valid one cycle after fifo_rd_en_o; {op(1=push,0=pop), tree_id, data}
- tree_valid_o  out  1  command valid
- tree_ready_i  in  1  tree array accepts command
- tree_op_o  out  1  1=push, 0=pop
- tree_id_o  out  TREE_NUM_BITS  target tree
- tree_data_o  out  PTW+MTW  push data (0 on pop)
- drop_o  out  1  one-cycle pulse when a task is discarded
- drop_cnt_o  out  16  saturating count of discarded tasks
- occ_o  out  TREE_NUM*CAP_BITS  per-tree occupancy, tree t at [t*CAP_BITS +: CAP_BITS]
- busy_o  out  1  read in flight or hold register occupied

## Operation
- Single-entry hold register (hold_valid, task) plus rd_pending flag.
- Fetch: fifo_rd_en_o = !fifo_empty_i && !rd_pending && (!hold_valid || hold_leaving). hold_leaving = issue or drop this cycle.
- rd_pending set on the cycle fifo_rd_en_o is high; next cycle fifo_data_i loads hold, rd_pending clears. Validity comes from rd_pending only, never from data content (FIFO outputs zero when not reading).
- Decode held task: push_full = op && occ[id]==TREE_CAP; pop_empty = !op && occ[id]==0; drop = hold_valid && (push_full || pop_empty).
- Drop: hold cleared that cycle, drop_o=1, drop_cnt_o += 1 (saturate at 16'hFFFF), no occupancy/cooldown change, tree_valid_o stays 0.
- Issue: tree_valid_o = hold_valid && !drop && cool[id]==0. Transfer on tree_valid_o && tree_ready_i. On transfer: occ[id] ±1, cool[id] loaded OP_GAP-1, hold cleared.
- Cooldown: each cool[t] decrements to 0 every cycle when nonzero. Stall on cooldown or !tree_ready_i holds all tree_* outputs stable (valid may not drop once raised until transfer).
- Strict in-order; head-of-line blocking on a cooling tree is required behaviour.
- tree_data_o forced 0 for pops.

## Timing
- Reset (async assert, sync release): fifo_rd_en_o=0, tree_valid_o=0, tree_op_o=0, tree_id_o=0, tree_data_o=0, drop_o=0, drop_cnt_o=0, occ_o=0, busy_o=0, all cool=0, rd_pending=0, hold_valid=0.
- Latency: rd_en in cycle n → hold loaded at end of n+1 → earliest tree_valid_o cycle n+2.
- Steady-state throughput: one task per 2 cycles (rd_en during the hold-leaving cycle).
- Same tree back-to-back: issues at cycles n and ≥ n+OP_GAP.
- Reset mid-read: in-flight FIFO word lost; occupancy restarts at 0.

## Structure
- Package bmw_task_pkg: task struct {op, tree_id, data}, op enum (OP_POP=0, OP_PUSH=1), width localparams; shared with the FIFO writer.
- Sub-module bmw_tree_slot: one per tree via generate; holds cool and occ counters, inputs inc/dec/load_cool, outputs ready (cool==0), full, empty.

## Test plan
- Reset, push tree 2 data 0x1234_5678 → tree_valid_o cycle 2 after rd_en, op=1, id=2; occ[2]=1.
- Pop to empty tree 1 → no tree_valid_o, drop_o one cycle, drop_cnt_o=1, occ unchanged.
- Two pushes to tree 0, OP_GAP=4 → issues exactly 4 cycles apart; third task to tree 3 waits behind (HOL).
- tree_ready_i low 5 cycles while valid → outputs stable, single transfer on ready, occ +1 only once.
- Fill tree 0 to TREE_CAP=4 (override), fifth push → dropped; pop then push → both issue, occ ends at 4.
- Assert rst_n low with rd_pending and hold_valid set → all outputs at reset values immediately; no issue after release until a new FIFO read.
